fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register of the Otter pipeline.
- Sits directly upstream of decode and the hazard/forwarding unit.
- Owns the PC and runs a single-outstanding-request handshake with instruction memory.
- Honours PCWrite/IF_ID_Write from the hazard unit, flushes on taken branches, and presents IF_ID_rs1/IF_ID_rs2 back to the hazard unit.

---
 rtl/otter_pipe_pkg.sv | 32 +++
 rtl/fetch_stage.sv | 140 ++++++++++++++
 tb/tb_fetch_stage.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/otter_pipe_pkg.sv
// Shared definitions for the Otter pipeline front end: fetch FSM states,
// the canonical bubble instruction and the register-field positions used
// by the hazard unit.
package otter_pipe_pkg;

    // Fetch handshake states: ISSUE sends a request, WAIT expects the reply,
    // HOLD parks a reply the pipeline could not take, DROP swallows a reply
    // that a redirect made stale.
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Source-register field positions inside an RV32 instruction word.
    localparam int REG_IDX_W = 5;
    localparam int RS1_LSB   = 15;
    localparam int RS2_LSB   = 20;

    function automatic logic [REG_IDX_W-1:0] rs1_of(input logic [31:0] instr);
        return instr[RS1_LSB +: REG_IDX_W];
    endfunction

    function automatic logic [REG_IDX_W-1:0] rs2_of(input logic [31:0] instr);
        return instr[RS2_LSB +: REG_IDX_W];
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register. Owns the PC, keeps
// at most one request outstanding to instruction memory, and obeys the
// hazard unit's stall controls and EX-stage redirects.
module fetch_stage
    import otter_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 PCWrite,
    input  logic                 IF_ID_Write,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic [31:0]          imem_rdata,
    input  logic                 imem_valid,
    output logic [31:0]          IF_ID_pc,
    output logic [31:0]          IF_ID_instr,
    output logic                 IF_ID_valid,
    output logic [REG_IDX_W-1:0] IF_ID_rs1,
    output logic [REG_IDX_W-1:0] IF_ID_rs2
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  hold_instr;
    logic [31:0]  target;
    logic         accept;
    logic         load_fire;
    logic [31:0]  load_instr;
    logic         unused_target_bits;

    // Redirects are always word aligned; the low target bits are ignored.
    assign target             = {branch_target[31:2], 2'b00};
    assign unused_target_bits = ^branch_target[1:0];

    assign accept    = PCWrite && IF_ID_Write;
    // Gated by reset so no request leaks out while the stage is held in reset.
    assign imem_req  = reset && (state == ISSUE) && !branch_taken;
    assign imem_addr = pc;

    assign IF_ID_rs1 = rs1_of(IF_ID_instr);
    assign IF_ID_rs2 = rs2_of(IF_ID_instr);

    // Decide whether IF/ID takes a new instruction this cycle, and from where.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        load_fire  = 1'b0;
        load_instr = imem_rdata;
        if (!branch_taken && accept) begin
            if (state == WAIT && imem_valid) begin
                load_fire = 1'b1;
            end else if (state == HOLD) begin
                load_fire  = 1'b1;
                load_instr = hold_instr;
            end
        end
    end

    // Fetch FSM: PC, handshake state and the parked-response buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ISSUE;
            pc         <= RESET_PC;
            hold_instr <= NOP_INSTR;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state)
                ISSUE: begin
                    if (branch_taken) begin
                        pc <= target;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_valid) begin
                        if (branch_taken) begin
                            pc    <= target;
                            state <= ISSUE;
                        end else if (accept) begin
                            pc    <= pc + 32'd4;
                            state <= ISSUE;
                        end else begin
                            hold_instr <= imem_rdata;
                            state      <= HOLD;
                        end
                    end else if (branch_taken) begin
                        // Reply still in flight; it must be swallowed later.
                        pc    <= target;
                        state <= DROP;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        pc         <= target;
                        hold_instr <= NOP_INSTR;
                        state      <= ISSUE;
                    end else if (accept) begin
                        pc         <= pc + 32'd4;
                        hold_instr <= NOP_INSTR;
                        state      <= ISSUE;
                    end
                end
                DROP: begin
                    if (branch_taken) begin
                        pc <= target;
                    end
                    if (imem_valid) begin
                        state <= ISSUE;
                    end
                end
                default: state <= ISSUE;
            endcase
        end
    end

    // IF/ID register: flush beats load, load beats stall, otherwise bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IF_ID_pc    <= 32'h0000_0000;
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end else if (branch_taken) begin
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end else if (load_fire) begin
            IF_ID_pc    <= pc;
            IF_ID_instr <= load_instr;
            IF_ID_valid <= 1'b1;
        end else if (IF_ID_Write) begin
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a vector table for streaming and
// stall behaviour, hand-written sequences for redirect, wrap and reset
// corners, and a scoreboard of expected IF/ID loads.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;
    logic [4:0]  IF_ID_rs1;
    logic [4:0]  IF_ID_rs2;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .PCWrite      (PCWrite),
        .IF_ID_Write  (IF_ID_Write),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_valid   (imem_valid),
        .IF_ID_pc     (IF_ID_pc),
        .IF_ID_instr  (IF_ID_instr),
        .IF_ID_valid  (IF_ID_valid),
        .IF_ID_rs1    (IF_ID_rs1),
        .IF_ID_rs2    (IF_ID_rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic        pw;
        logic        iw;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_new;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[11];
    int          checks   = 0;
    int          failures = 0;
    logic        auto_mem = 1'b0;
    logic [31:0] last_instr = NOP;

    // Memory contents: a scrambled function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock edge; the 1-cycle memory model answers requests seen before it.
    task automatic tick();
        logic        req_seen;
        logic [31:0] addr_seen;
        req_seen  = imem_req;
        addr_seen = imem_addr;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            imem_valid = req_seen;
            imem_rdata = req_seen ? mem_word(addr_seen) : 32'h0;
        end
        #1;
    endtask

    task automatic expect_load(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, IF_ID_pc=%h", name, IF_ID_pc);
        end else begin
            e = sb.pop_front();
            check({name, "_valid"}, 32'(IF_ID_valid), 32'd1);
            check({name, "_pc"},    IF_ID_pc, e.pc);
            check({name, "_instr"}, IF_ID_instr, e.instr);
            check({name, "_rs1"},   32'(IF_ID_rs1), 32'(e.instr[19:15]));
            check({name, "_rs2"},   32'(IF_ID_rs2), 32'(e.instr[24:20]));
            last_instr = e.instr;
        end
    endtask

    task automatic expect_bubble(input string name);
        check({name, "_valid"}, 32'(IF_ID_valid), 32'd0);
        check({name, "_instr"}, IF_ID_instr, NOP);
        check({name, "_rs1"},   32'(IF_ID_rs1), 32'd0);
        check({name, "_rs2"},   32'(IF_ID_rs2), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming with 1-cycle memory, then a 4-cycle stall across a reply.
        //           pw    iw    req   addr          valid  if_pc         new
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0004, 1'b1, 32'h0000_0004, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0004, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0004, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0004, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0008, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0000_0008, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_000C, 1'b1};

        reset         = 1'b0;
        PCWrite       = 1'b0;
        IF_ID_Write   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_rdata    = 32'h0;
        imem_valid    = 1'b0;

        // Reset state.
        repeat (3) tick();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0000_0000);
        check("rst_if_pc", IF_ID_pc, 32'h0000_0000);
        expect_bubble("rst");

        reset    = 1'b1;
        auto_mem = 1'b1;

        // Table-driven streaming and stall.
        for (int i = 0; i < 11; i++) begin
            PCWrite     = vecs[i].pw;
            IF_ID_Write = vecs[i].iw;
            #1;
            check($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            if (vecs[i].exp_req)
                sb.push_back('{vecs[i].exp_addr, mem_word(vecs[i].exp_addr)});
            tick();
            if (vecs[i].exp_new) begin
                expect_load($sformatf("v%0d_load", i));
            end else begin
                check($sformatf("v%0d_valid", i), 32'(IF_ID_valid), 32'(vecs[i].exp_valid));
                check($sformatf("v%0d_if_pc", i), IF_ID_pc, vecs[i].exp_pc);
                if (vecs[i].exp_valid)
                    check($sformatf("v%0d_held_instr", i), IF_ID_instr, last_instr);
                else
                    check($sformatf("v%0d_nop", i), IF_ID_instr, NOP);
            end
        end

        // Redirect while waiting: reply dropped, fetch resumes at aligned target.
        auto_mem = 1'b0;
        #1;
        check("drop_req0", 32'(imem_req), 32'd1);
        check("drop_addr0", imem_addr, 32'h0000_0010);
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0102;
        #1;
        check("drop_req_br", 32'(imem_req), 32'd0);
        tick();
        branch_taken = 1'b0;
        expect_bubble("drop_flush");
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("drop_no_req", 32'(imem_req), 32'd0);
        tick();
        imem_valid = 1'b0;
        expect_bubble("drop_discard");
        #1;
        check("drop_req_tgt", 32'(imem_req), 32'd1);
        check("drop_addr_tgt", imem_addr, 32'h0000_0100);
        auto_mem = 1'b1;
        sb.push_back('{32'h0000_0100, mem_word(32'h0000_0100)});
        tick();
        tick();
        expect_load("drop_refetch");

        // Redirect and reply together while IF/ID is stalled: flush wins.
        auto_mem    = 1'b0;
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        #1;
        check("fh_req", 32'(imem_req), 32'd1);
        check("fh_addr", imem_addr, 32'h0000_0104);
        tick();
        check("fh_stall_keep", 32'(IF_ID_valid), 32'd1);
        imem_valid    = 1'b1;
        imem_rdata    = 32'hCAFE_F00D;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0200;
        tick();
        branch_taken = 1'b0;
        imem_valid   = 1'b0;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        expect_bubble("fh_flush");
        #1;
        check("fh_req_tgt", 32'(imem_req), 32'd1);
        check("fh_addr_tgt", imem_addr, 32'h0000_0200);

        // Redirect from ISSUE to the top word, then wrap to zero.
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        #1;
        check("wrap_req_br", 32'(imem_req), 32'd0);
        tick();
        branch_taken = 1'b0;
        #1;
        check("wrap_req_top", 32'(imem_req), 32'd1);
        check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        auto_mem = 1'b1;
        sb.push_back('{32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
        tick();
        tick();
        expect_load("wrap_load");
        #1;
        check("wrap_req", 32'(imem_req), 32'd1);
        check("wrap_addr", imem_addr, 32'h0000_0000);
        sb.push_back('{32'h0000_0000, mem_word(32'h0000_0000)});
        tick();
        tick();
        expect_load("pre_rst_load");

        // Reset in WAIT with the reply arriving during reset.
        #1;
        check("mid_req", 32'(imem_req), 32'd1);
        check("mid_addr", imem_addr, 32'h0000_0004);
        tick();
        auto_mem = 1'b0;
        reset    = 1'b0;
        #1;
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_addr", imem_addr, 32'h0000_0000);
        check("mid_rst_if_pc", IF_ID_pc, 32'h0000_0000);
        expect_bubble("mid_rst");
        tick();
        check("mid_rst_hold_valid", 32'(IF_ID_valid), 32'd0);
        imem_rdata = 32'hBAD0_BAD0;
        reset      = 1'b1;
        #1;
        check("post_rst_req", 32'(imem_req), 32'd1);
        check("post_rst_addr", imem_addr, 32'h0000_0000);
        tick();
        expect_bubble("late_valid_ignored");
        imem_valid = 1'b1;
        imem_rdata = mem_word(32'h0000_0000);
        sb.push_back('{32'h0000_0000, mem_word(32'h0000_0000)});
        tick();
        imem_valid = 1'b0;
        expect_load("post_rst_load");

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
